// File: rtl/mul2_pkg.sv
// Shared definitions for the 2x2 unsigned multiplier lab block.
// Contents:
//   state_e   - sweep checker FSM encoding
//   VEC_LAST  - last operand vector of a sweep
//   mul2_gold - reference product {a,b}*{c,d} for operand {a,b,c,d}
package mul2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [3:0] VEC_LAST = 4'hF;

  // Operand layout is {a,b,c,d}; the product of two 2-bit values fits 4 bits.
  function automatic logic [3:0] mul2_gold(input logic [3:0] op);
    return {2'b00, op[3:2]} * {2'b00, op[1:0]};
  endfunction

endpackage

// File: rtl/mul2_sweep_checker_if.sv
// Bus between the sweep checker and its environment (host control plus
// the three multiplier implementations under test).
//   start, abort         - sweep control from the host
//   operand              - {a,b,c,d} driven to all implementations
//   res_ssi/dec/mux      - {f3,f2,f1,f0} returned by each implementation
//   busy, done, pass     - sweep status
//   err_count            - vectors with any mismatch (0..16)
//   first_err_vec/src    - operand and {mux,dec,ssi} mask of first failure
// slave is the checker's view, master is the environment's view.
interface mul2_sweep_checker_if;
  logic       start;
  logic       abort;
  logic [3:0] operand;
  logic [3:0] res_ssi;
  logic [3:0] res_dec;
  logic [3:0] res_mux;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic [3:0] first_err_vec;
  logic [2:0] first_err_src;

  modport slave (
    input  start, abort, res_ssi, res_dec, res_mux,
    output operand, busy, done, pass, err_count, first_err_vec, first_err_src
  );

  modport master (
    output start, abort, res_ssi, res_dec, res_mux,
    input  operand, busy, done, pass, err_count, first_err_vec, first_err_src
  );
endinterface

// File: rtl/mul2_cmp.sv
// Combinational comparator: checks the three implementation results
// against the golden product of the current operand.
//   operand_i  - {a,b,c,d}
//   res_*_i    - results of the SSI, decoder and MUX implementations
//   mask_o     - {mux,dec,ssi} mismatch mask, bit set = wrong result
module mul2_cmp
  import mul2_pkg::*;
(
  input  logic [3:0] operand_i,
  input  logic [3:0] res_ssi_i,
  input  logic [3:0] res_dec_i,
  input  logic [3:0] res_mux_i,
  output logic [2:0] mask_o
);

  logic [3:0] gold;

  assign gold   = mul2_gold(operand_i);
  assign mask_o = {res_mux_i != gold, res_dec_i != gold, res_ssi_i != gold};

endmodule

// File: rtl/mul2_sweep_checker.sv
// On-chip verifier for the 2x2 multiplier implementations. Sweeps all 16
// operands, waits SETTLE_CYCLES+1 cycles per vector, then compares the
// three results against the golden product and records the outcome.
//   clk, rst - system clock, asynchronous active-high reset
//   bus      - mul2_sweep_checker_if.slave (control, operand, results, status)
// All status outputs come straight from registers.
module mul2_sweep_checker
  import mul2_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  mul2_sweep_checker_if.slave    bus
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] operand_q, operand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] err_q, err_d;
  logic [3:0] fev_q, fev_d;
  logic [2:0] fes_q, fes_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [2:0] mask;

  mul2_cmp u_cmp (
    .operand_i (operand_q),
    .res_ssi_i (bus.res_ssi),
    .res_dec_i (bus.res_dec),
    .res_mux_i (bus.res_mux),
    .mask_o    (mask)
  );

  always_comb begin
    // NOTE: every next-state value defaults to its register first, so no
    // path through the case leaves a signal unassigned (no latches).
    state_d   = state_q;
    operand_d = operand_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    fev_d     = fev_q;
    fes_d     = fes_q;
    pass_d    = pass_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          operand_d = '0;
          cnt_d     = SETTLE_INIT;
          err_d     = '0;
          fev_d     = '0;
          fes_d     = '0;
          pass_d    = 1'b0;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          pass_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CHECK: begin
        // abort wins over the result update of this vector
        if (bus.abort) begin
          pass_d  = 1'b0;
          state_d = IDLE;
        end else begin
          if (mask != 3'b000) begin
            err_d = err_q + 5'd1;
            if (err_q == 5'd0) begin
              fev_d = operand_q;
              fes_d = mask;
            end
          end
          if (operand_q == VEC_LAST) begin
            state_d = DONE;
          end else begin
            operand_d = operand_q + 4'd1;
            cnt_d     = SETTLE_INIT;
            state_d   = SETTLE;
          end
        end
      end
      DONE: begin
        pass_d  = (err_q == 5'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // busy/done are registered copies of the state being entered
    busy_d = (state_d == SETTLE) || (state_d == CHECK);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      operand_q <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      fev_q     <= '0;
      fes_q     <= '0;
      pass_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge values, independent of statement order.
      state_q   <= state_d;
      operand_q <= operand_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      fev_q     <= fev_d;
      fes_q     <= fes_d;
      pass_q    <= pass_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.operand       = operand_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_vec = fev_q;
  assign bus.first_err_src = fes_q;

endmodule
